// File: rtl/instr_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// instr_mem_rr_arbiter
//
// Shares one synchronous-read instruction memory between N_CPU single-cycle
// CPUs. Each cycle at most one requesting CPU is granted, round-robin, and its
// address is driven to the memory. The memory word comes back one cycle later
// and is broadcast on cpu_rdata, qualified per CPU by cpu_rvalid.
//
// A CPU stalls on (cpu_req & ~cpu_gnt); its PC register enable is cpu_rvalid.
//
// Ports
//   clk         in   clock, all state on posedge
//   rst_n       in   asynchronous active-low reset
//   cpu_req     in   [N_CPU]      per-CPU fetch request
//   cpu_addr    in   [N_CPU*AW]   CPU i address in bits [i*AW +: AW]
//   cpu_gnt     out  [N_CPU]      one-hot (or zero) grant, combinational
//   cpu_rvalid  out  [N_CPU]      registered, cpu_rdata belongs to CPU i
//   cpu_rdata   out  [DW]         broadcast read data (= imem_rdata)
//   imem_en     out               memory read strobe
//   imem_addr   out  [AW]         memory address, 0 when idle
//   imem_rdata  in   [DW]         memory data, valid the cycle after imem_en
//   grant_cnt   out  [N_CPU*CNT_W] saturating per-CPU grant counters
//
// Optional feature: define IMEM_ARB_GRANT_CNT_EN to add the CNT_W parameter,
// the grant counters and the grant_cnt port. Arbitration and timing are the
// same with or without it.
// ---------------------------------------------------------------------------
module instr_mem_rr_arbiter #(
    parameter int N_CPU = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
`ifdef IMEM_ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CPU-1:0]      cpu_req,
    input  logic [N_CPU*AW-1:0]   cpu_addr,
    output logic [N_CPU-1:0]      cpu_gnt,
    output logic [N_CPU-1:0]      cpu_rvalid,
    output logic [DW-1:0]         cpu_rdata,
    output logic                  imem_en,
    output logic [AW-1:0]         imem_addr,
    input  logic [DW-1:0]         imem_rdata
`ifdef IMEM_ARB_GRANT_CNT_EN
    ,
    output logic [N_CPU*CNT_W-1:0] grant_cnt
`endif
);

    localparam int LW = (N_CPU > 1) ? $clog2(N_CPU) : 1;

    logic [LW-1:0]    last_q;
    logic [N_CPU-1:0] rvalid_q;
    logic [LW-1:0]    win_idx;
    logic [LW-1:0]    cand;
    logic             found;

    // Index k positions after base, wrapping at N_CPU.
    function automatic logic [LW-1:0] rr_index(input logic [LW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CPU) s = s - N_CPU;
        return LW'(s);
    endfunction

    // Stage 0: combinational round-robin search, starting just after the
    // last winner so that the previous winner has the lowest priority.
    always_comb begin
        win_idx = last_q;
        cand    = last_q;
        found   = 1'b0;
        for (int k = 1; k <= N_CPU; k++) begin
            cand = rr_index(last_q, k);
            if (!found && cpu_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        // No grant may escape while the arbiter is held in reset.
        if (!rst_n) found = 1'b0;
    end

    always_comb begin
        cpu_gnt = '0;
        if (found) cpu_gnt[win_idx] = 1'b1;
    end

    always_comb begin
        imem_addr = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (cpu_gnt[i]) imem_addr = cpu_addr[i*AW +: AW];
        end
    end

    assign imem_en = found;

    // Stage 1: pointer and read-valid tracking. The memory itself provides
    // the one-cycle data delay, so only the owner of the data is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= LW'(N_CPU - 1);
            rvalid_q <= '0;
        end else begin
            rvalid_q <= cpu_gnt;
            if (found) last_q <= win_idx;
        end
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = imem_rdata;

`ifdef IMEM_ARB_GRANT_CNT_EN
    logic [N_CPU*CNT_W-1:0] cnt_q;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CPU; i++) begin
                if (cpu_gnt[i]) cnt_q[i*CNT_W +: CNT_W] <= sat_inc(cnt_q[i*CNT_W +: CNT_W]);
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

`ifndef SYNTHESIS
    // A waiting requester must keep its address until it is granted.
    for (genvar g = 0; g < N_CPU; g++) begin : g_addr_hold
        a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (cpu_req[g] && !cpu_gnt[g]) |=> $stable(cpu_addr[g*AW +: AW]))
            else $error("cpu_addr[%0d] changed while waiting for grant", g);
    end
`endif

endmodule

// File: tb/tb_instr_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_rr_arbiter
//
// Directed vector table, hand-written reset-mid-operation sequence and a
// randomized phase checked against a distance-based round-robin model.
// The bench acts as the synchronous memory: data = address >> 2.
// ---------------------------------------------------------------------------
module tb_instr_mem_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    cpu_req;
    logic [N*AW-1:0] cpu_addr;
    logic [N-1:0]    cpu_gnt;
    logic [N-1:0]    cpu_rvalid;
    logic [DW-1:0]   cpu_rdata;
    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [DW-1:0]   imem_rdata;
`ifdef IMEM_ARB_GRANT_CNT_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    instr_mem_rr_arbiter #(
        .N_CPU(N),
        .AW(AW),
        .DW(DW)
`ifdef IMEM_ARB_GRANT_CNT_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata)
`ifdef IMEM_ARB_GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic          en_s;
    logic [AW-1:0] addr_s;

    typedef struct {
        logic [2:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [2:0]  gnt;
        logic [31:0] addr;
        logic [2:0]  rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2);
        cpu_req  = r;
        cpu_addr = {a2, a1, a0};
    endtask

    // Checks one cycle at the falling edge, then advances past the rising
    // edge and plays the memory's registered read.
    task automatic run_cycle(input string tag, input logic [2:0] eg, input logic [31:0] ea,
                             input logic [2:0] erv, input logic [31:0] erd);
        @(negedge clk);
        chk({tag, ".gnt"},    32'(cpu_gnt),    32'(eg));
        chk({tag, ".en"},     32'(imem_en),    32'(|eg));
        chk({tag, ".addr"},   imem_addr,       ea);
        chk({tag, ".rvalid"}, 32'(cpu_rvalid), 32'(erv));
        if (erv != 3'b000) chk({tag, ".rdata"}, cpu_rdata, erd);
        en_s   = imem_en;
        addr_s = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = en_s ? (addr_s >> 2) : 32'hBAD0_BAD0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Random-phase model state
    int          ref_last;
    logic [2:0]  ref_prev_gnt;
    logic [31:0] ref_prev_rd;
    logic [2:0]  rreq;
    logic [31:0] raddr [3];
    int          cnt_m [3];

    initial begin
        //           req     a0      a1      a2      gnt     addr    rv      rd
        vecs[0]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b001, 32'h100, 3'b000, 32'h0};
        vecs[1]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b010, 32'h200, 3'b001, 32'h40};
        vecs[2]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b100, 32'h300, 3'b010, 32'h80};
        vecs[3]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b001, 32'h100, 3'b100, 32'hC0};
        vecs[4]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b010, 32'h200, 3'b001, 32'h40};
        vecs[5]  = '{3'b111, 32'h100, 32'h200, 32'h300, 3'b100, 32'h300, 3'b010, 32'h80};
        vecs[6]  = '{3'b011, 32'h100, 32'h200, 32'h0,   3'b001, 32'h100, 3'b100, 32'hC0};
        vecs[7]  = '{3'b010, 32'h0,   32'h200, 32'h0,   3'b010, 32'h200, 3'b001, 32'h40};
        vecs[8]  = '{3'b010, 32'h0,   32'h40,  32'h0,   3'b010, 32'h40,  3'b010, 32'h80};
        vecs[9]  = '{3'b010, 32'h0,   32'h44,  32'h0,   3'b010, 32'h44,  3'b010, 32'h10};
        vecs[10] = '{3'b010, 32'h0,   32'h48,  32'h0,   3'b010, 32'h48,  3'b010, 32'h11};
        vecs[11] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b010, 32'h12};
        vecs[12] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b000, 32'h0};
        vecs[13] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b000, 32'h0};
        vecs[14] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b000, 32'h0};
        vecs[15] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b000, 32'h0};
        vecs[16] = '{3'b100, 32'h0,   32'h0,   32'h300, 3'b100, 32'h300, 3'b000, 32'h0};
        vecs[17] = '{3'b011, 32'h100, 32'h200, 32'h0,   3'b001, 32'h100, 3'b100, 32'hC0};
        vecs[18] = '{3'b011, 32'h104, 32'h200, 32'h0,   3'b010, 32'h200, 3'b001, 32'h40};
        vecs[19] = '{3'b001, 32'h104, 32'h0,   32'h0,   3'b001, 32'h104, 3'b010, 32'h80};
        vecs[20] = '{3'b000, 32'h0,   32'h0,   32'h0,   3'b000, 32'h0,   3'b001, 32'h41};

        // Reset state, with every CPU requesting
        rst_n      = 1'b0;
        imem_rdata = '0;
        drive(3'b111, 32'h100, 32'h200, 32'h300);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt",    32'(cpu_gnt),    32'h0);
        chk("rst.en",     32'(imem_en),    32'h0);
        chk("rst.addr",   imem_addr,       32'h0);
        chk("rst.rvalid", 32'(cpu_rvalid), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2);
            run_cycle($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].addr, vecs[i].rv, vecs[i].rd);
        end

        // Reset in the cycle after a CPU0 grant (pointer would favour CPU1)
        drive(3'b001, 32'h10, 32'h0, 32'h0);
        run_cycle("pre_rst", 3'b001, 32'h10, 3'b000, 32'h0);
        chk("pre_rst.rvalid_now", 32'(cpu_rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("in_rst.rvalid", 32'(cpu_rvalid), 32'h0);
        chk("in_rst.gnt",    32'(cpu_gnt),    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b111, 32'h100, 32'h200, 32'h300);
        run_cycle("post_rst0", 3'b001, 32'h100, 3'b000, 32'h0);
        run_cycle("post_rst1", 3'b010, 32'h200, 3'b001, 32'h40);

`ifdef IMEM_ARB_GRANT_CNT_EN
        // CPU0 alone: counter climbs to all-ones and holds there
        cpu_req = 3'b000;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b001, 32'h20, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            run_cycle("cnt", 3'b001, 32'h20, (k == 0) ? 3'b000 : 3'b001, 32'h8);
            chk($sformatf("cnt%0d.grant_cnt", k), 32'(grant_cnt), 32'((k + 1 > 3) ? 3 : k + 1));
        end
`endif

        // Randomized phase against the round-robin model
        cpu_req = 3'b000;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        ref_last     = N - 1;
        ref_prev_gnt = 3'b000;
        ref_prev_rd  = 32'h0;
        for (int i = 0; i < N; i++) begin
            rreq[i]  = ($urandom % 4) != 0;
            raddr[i] = $urandom & 32'hFFFF_FFFC;
            cnt_m[i] = 0;
        end
        drive(rreq, raddr[0], raddr[1], raddr[2]);

        for (int cyc = 0; cyc < 400; cyc++) begin
            int          best;
            int          bestd;
            logic [2:0]  eg;
            logic [31:0] ea;
            logic [5:0]  ecnt;
            best  = -1;
            bestd = N;
            // Winner: requester closest after the previous winner
            for (int i = 0; i < N; i++) begin
                int d;
                d = (i - ref_last - 1 + 2 * N) % N;
                if (rreq[i] && d < bestd) begin
                    best  = i;
                    bestd = d;
                end
            end
            eg = (best >= 0) ? 3'(1 << best) : 3'b000;
            ea = (best >= 0) ? raddr[best] : 32'h0;
            run_cycle("rnd", eg, ea, ref_prev_gnt, ref_prev_rd);

            if (best >= 0) begin
                ref_last     = best;
                ref_prev_rd  = ea >> 2;
                cnt_m[best]  = (cnt_m[best] >= 3) ? 3 : cnt_m[best] + 1;
            end
            ref_prev_gnt = eg;
            ecnt = {2'(cnt_m[2]), 2'(cnt_m[1]), 2'(cnt_m[0])};
`ifdef IMEM_ARB_GRANT_CNT_EN
            chk("rnd.grant_cnt", 32'(grant_cnt), 32'(ecnt));
`endif

            // Waiting requesters hold; others pick a fresh request
            for (int i = 0; i < N; i++) begin
                if (!(rreq[i] && best != i)) begin
                    rreq[i]  = ($urandom % 4) != 0;
                    raddr[i] = $urandom & 32'hFFFF_FFFC;
                end
            end
            drive(rreq, raddr[0], raddr[1], raddr[2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
